// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, T-state numbers,
// control-word bit positions and the per-opcode last active execute step.
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   localparam int unsigned T0 = 0;
   localparam int unsigned T1 = 1;
   localparam int unsigned T2 = 2;
   localparam int unsigned T3 = 3;
   localparam int unsigned T4 = 4;
   localparam int unsigned T5 = 5;

   localparam int unsigned CW_W        = 15;
   localparam int unsigned CW_PC_RD    = 0;
   localparam int unsigned CW_PC_WR    = 1;
   localparam int unsigned CW_PC_INC   = 2;
   localparam int unsigned CW_MAR_WR   = 3;
   localparam int unsigned CW_RAM_RD   = 4;
   localparam int unsigned CW_RAM_WR   = 5;
   localparam int unsigned CW_IR_WR    = 6;
   localparam int unsigned CW_IR_RD    = 7;
   localparam int unsigned CW_A_WR     = 8;
   localparam int unsigned CW_A_RD     = 9;
   localparam int unsigned CW_B_WR     = 10;
   localparam int unsigned CW_ALU_RD   = 11;
   localparam int unsigned CW_ALU_SUB  = 12;
   localparam int unsigned CW_FLAGS_WR = 13;
   localparam int unsigned CW_OUT_WR   = 14;

   function automatic int unsigned last_step(input logic [3:0] op);
      case (op)
         OP_LDA, OP_STA: return T3;
         OP_ADD, OP_SUB: return T4;
         default:        return T2;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_step_ctr.sv
// T-state counter: holds when told to, wraps at NSTEPS-1 or on an early-wrap request.
module ctrl_step_ctr #(
   parameter int unsigned NSTEPS = 6,
   parameter int unsigned SW     = $clog2(NSTEPS)
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          hold,
   input  logic          early_wrap,
   output logic [SW-1:0] step
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         step <= '0;
      end else if (!hold) begin
         if (step == SW'(NSTEPS - 1) || early_wrap) begin
            step <= '0;
         end else begin
            step <= step + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer for the 8-bit CPU: T-state stepping, halt flag and opcode decode.
// Optional feature: define EARLY_FETCH_EN to restart fetch right after an opcode's last active step.
module ctrl_seq
   import ctrl_pkg::*;
#(
   parameter int unsigned NSTEPS = 6,
   parameter int unsigned OPW    = 4
) (
   input  logic                      clk,
   input  logic                      clr_n,
   input  logic                      run,
   input  logic [OPW-1:0]            ir_op,
   input  logic                      flag_c,
   input  logic                      flag_z,
   output logic [$clog2(NSTEPS)-1:0] step,
   output logic                      pc_rd,
   output logic                      pc_wr,
   output logic                      pc_inc,
   output logic                      mar_wr,
   output logic                      ram_rd,
   output logic                      ram_wr,
   output logic                      ir_wr,
   output logic                      ir_rd,
   output logic                      a_wr,
   output logic                      a_rd,
   output logic                      b_wr,
   output logic                      alu_rd,
   output logic                      alu_sub,
   output logic                      flags_wr,
   output logic                      out_wr,
   output logic                      halted
);

   localparam int unsigned SW = $clog2(NSTEPS);

   logic [3:0]      op;
   logic            active;
   logic            halt_now;
   logic            halted_q;
   logic            halted_d;
   logic            early_wrap;
   logic [CW_W-1:0] cw;

   assign op     = 4'(ir_op);
   assign active = run && !halted_q;

`ifdef EARLY_FETCH_EN
   assign early_wrap = (step == SW'(last_step(op)));
`else
   assign early_wrap = 1'b0;
`endif

   // HLT must also freeze the counter on the very edge that sets halted, so step stays at T2
   ctrl_step_ctr #(.NSTEPS(NSTEPS), .SW(SW)) u_step (
      .clk       (clk),
      .clr_n     (clr_n),
      .hold      (!active || halt_now),
      .early_wrap(early_wrap),
      .step      (step)
   );

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   always_comb begin
      halt_now = active && (op == OP_HLT) && (step == SW'(T2));
      halted_d = halted_q || halt_now;
   end

   always_comb begin
      cw = '0;
      if (clr_n && active) begin
         case (step)
            SW'(T0): begin
               cw[CW_PC_RD]  = 1'b1;
               cw[CW_MAR_WR] = 1'b1;
            end
            SW'(T1): begin
               cw[CW_RAM_RD] = 1'b1;
               cw[CW_IR_WR]  = 1'b1;
               cw[CW_PC_INC] = 1'b1;
            end
            SW'(T2): begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     cw[CW_IR_RD]  = 1'b1;
                     cw[CW_MAR_WR] = 1'b1;
                  end
                  OP_LDI: begin
                     cw[CW_IR_RD] = 1'b1;
                     cw[CW_A_WR]  = 1'b1;
                  end
                  OP_JMP: begin
                     cw[CW_IR_RD] = 1'b1;
                     cw[CW_PC_WR] = 1'b1;
                  end
                  OP_JC: begin
                     cw[CW_IR_RD] = 1'b1;
                     cw[CW_PC_WR] = flag_c;
                  end
                  OP_JZ: begin
                     cw[CW_IR_RD] = 1'b1;
                     cw[CW_PC_WR] = flag_z;
                  end
                  OP_OUT: begin
                     cw[CW_A_RD]   = 1'b1;
                     cw[CW_OUT_WR] = 1'b1;
                  end
                  default: ;
               endcase
            end
            SW'(T3): begin
               case (op)
                  OP_LDA: begin
                     cw[CW_RAM_RD] = 1'b1;
                     cw[CW_A_WR]   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     cw[CW_RAM_RD] = 1'b1;
                     cw[CW_B_WR]   = 1'b1;
                  end
                  OP_STA: begin
                     cw[CW_A_RD]   = 1'b1;
                     cw[CW_RAM_WR] = 1'b1;
                  end
                  default: ;
               endcase
            end
            SW'(T4): begin
               if (op == OP_ADD || op == OP_SUB) begin
                  cw[CW_ALU_RD]   = 1'b1;
                  cw[CW_A_WR]     = 1'b1;
                  cw[CW_FLAGS_WR] = 1'b1;
                  cw[CW_ALU_SUB]  = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign pc_rd    = cw[CW_PC_RD];
   assign pc_wr    = cw[CW_PC_WR];
   assign pc_inc   = cw[CW_PC_INC];
   assign mar_wr   = cw[CW_MAR_WR];
   assign ram_rd   = cw[CW_RAM_RD];
   assign ram_wr   = cw[CW_RAM_WR];
   assign ir_wr    = cw[CW_IR_WR];
   assign ir_rd    = cw[CW_IR_RD];
   assign a_wr     = cw[CW_A_WR];
   assign a_rd     = cw[CW_A_RD];
   assign b_wr     = cw[CW_B_WR];
   assign alu_rd   = cw[CW_ALU_RD];
   assign alu_sub  = cw[CW_ALU_SUB];
   assign flags_wr = cw[CW_FLAGS_WR];
   assign out_wr   = cw[CW_OUT_WR];
   assign halted   = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: an instruction-level model queues expected outputs,
// a monitor compares them against the DUT every cycle.
module tb_ctrl_seq;

   localparam int unsigned NSTEPS = 6;
`ifdef EARLY_FETCH_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   localparam logic [14:0] PC_RD    = 15'h0001;
   localparam logic [14:0] PC_WR    = 15'h0002;
   localparam logic [14:0] PC_INC   = 15'h0004;
   localparam logic [14:0] MAR_WR   = 15'h0008;
   localparam logic [14:0] RAM_RD   = 15'h0010;
   localparam logic [14:0] RAM_WR   = 15'h0020;
   localparam logic [14:0] IR_WR    = 15'h0040;
   localparam logic [14:0] IR_RD    = 15'h0080;
   localparam logic [14:0] A_WR     = 15'h0100;
   localparam logic [14:0] A_RD     = 15'h0200;
   localparam logic [14:0] B_WR     = 15'h0400;
   localparam logic [14:0] ALU_RD   = 15'h0800;
   localparam logic [14:0] ALU_SUB  = 15'h1000;
   localparam logic [14:0] FLAGS_WR = 15'h2000;
   localparam logic [14:0] OUT_WR   = 15'h4000;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       run = 1'b0;
   logic [3:0] ir_op = 4'h0;
   logic       flag_c = 1'b0;
   logic       flag_z = 1'b0;
   logic [2:0] step;
   logic pc_rd, pc_wr, pc_inc, mar_wr, ram_rd, ram_wr, ir_wr, ir_rd;
   logic a_wr, a_rd, b_wr, alu_rd, alu_sub, flags_wr, out_wr, halted;

   always #5 clk = ~clk;

   ctrl_seq #(.NSTEPS(NSTEPS), .OPW(4)) dut (
      .clk(clk), .clr_n(clr_n), .run(run), .ir_op(ir_op), .flag_c(flag_c), .flag_z(flag_z),
      .step(step), .pc_rd(pc_rd), .pc_wr(pc_wr), .pc_inc(pc_inc), .mar_wr(mar_wr),
      .ram_rd(ram_rd), .ram_wr(ram_wr), .ir_wr(ir_wr), .ir_rd(ir_rd), .a_wr(a_wr),
      .a_rd(a_rd), .b_wr(b_wr), .alu_rd(alu_rd), .alu_sub(alu_sub), .flags_wr(flags_wr),
      .out_wr(out_wr), .halted(halted)
   );

   logic [14:0] got_cw;
   assign got_cw = {out_wr, flags_wr, alu_sub, alu_rd, b_wr, a_rd, a_wr, ir_rd, ir_wr,
                    ram_wr, ram_rd, mar_wr, pc_inc, pc_wr, pc_rd};

   typedef struct {
      logic [2:0]  step;
      logic        halted;
      logic [14:0] cw;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [14:0] tbl[16][3];
   int          mstep = 0;
   bit          mhalted = 1'b0;

   // Execute micro-steps T2..T4 per opcode; anything not listed behaves as NOP
   task automatic init_tbl();
      for (int o = 0; o < 16; o++) for (int k = 0; k < 3; k++) tbl[o][k] = '0;
      tbl[1]  = '{IR_RD | MAR_WR, RAM_RD | A_WR, 15'h0};
      tbl[2]  = '{IR_RD | MAR_WR, RAM_RD | B_WR, ALU_RD | A_WR | FLAGS_WR};
      tbl[3]  = '{IR_RD | MAR_WR, RAM_RD | B_WR, ALU_RD | A_WR | FLAGS_WR | ALU_SUB};
      tbl[4]  = '{IR_RD | MAR_WR, A_RD | RAM_WR, 15'h0};
      tbl[5]  = '{IR_RD | A_WR, 15'h0, 15'h0};
      tbl[6]  = '{IR_RD | PC_WR, 15'h0, 15'h0};
      tbl[7]  = '{IR_RD | PC_WR, 15'h0, 15'h0};
      tbl[8]  = '{IR_RD | PC_WR, 15'h0, 15'h0};
      tbl[14] = '{A_RD | OUT_WR, 15'h0, 15'h0};
   endtask

   function automatic logic [14:0] model_word(int op, int t, bit c, bit z);
      logic [14:0] w;
      if (t == 0) return PC_RD | MAR_WR;
      if (t == 1) return RAM_RD | IR_WR | PC_INC;
      if (t > 4) return '0;
      w = tbl[op][t-2];
      if ((op == 7 && !c) || (op == 8 && !z)) w = w & ~PC_WR;
      return w;
   endfunction

   function automatic int last_active(int op);
      int ls = 2;
      for (int k = 0; k < 3; k++) if (tbl[op][k] != '0) ls = k + 2;
      return ls;
   endfunction

   task automatic cycle(input bit clr, input bit r, input int op, input bit c, input bit z);
      exp_t e;
      @(negedge clk);
      clr_n = clr; run = r; ir_op = 4'(op); flag_c = c; flag_z = z;
      e.step   = 3'(mstep);
      e.halted = mhalted;
      e.cw     = (clr && r && !mhalted) ? model_word(op, mstep, c, z) : '0;
      sb.push_back(e);
      if (!clr) begin
         mstep = 0; mhalted = 1'b0;
      end else if (r && !mhalted) begin
         if (op == 15 && mstep == 2) mhalted = 1'b1;
         else if (mstep == NSTEPS - 1 || (EARLY && mstep == last_active(op))) mstep = 0;
         else mstep = mstep + 1;
      end
   endtask

   task automatic run_instr(input int op, input bit c, input bit z);
      for (int i = 0; i < NSTEPS; i++) begin
         cycle(1'b1, 1'b1, op, c, z);
         if (mstep == 0 || mhalted) break;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (step !== e.step) begin
               errors++; $display("FAIL step: got %0d expected %0d", step, e.step);
            end
            checks++;
            if (halted !== e.halted) begin
               errors++; $display("FAIL halted: got %0b expected %0b", halted, e.halted);
            end
            checks++;
            if (got_cw !== e.cw) begin
               errors++;
               $display("FAIL ctrl: got %04h expected %04h (step %0d op %0h)", got_cw, e.cw, e.step, ir_op);
            end
            checks++;
            if ($countones({pc_rd, ram_rd, ir_rd, a_rd, alu_rd}) > 1) begin
               errors++;
               $display("FAIL bus_onehot: got drivers %05b required at most one",
                        {pc_rd, ram_rd, ir_rd, a_rd, alu_rd});
            end
         end
      end
   end

   initial begin : stimulus
      int op;
      init_tbl();
      // reset held for two edges
      cycle(1'b0, 1'b1, 1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1, 1'b0, 1'b0);
      // LDA, then a following fetch to see the wrap
      run_instr(1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 0, 1'b0, 1'b0);
      // conditional jumps with each flag value
      run_instr(7, 1'b0, 1'b1);
      run_instr(7, 1'b1, 1'b0);
      run_instr(8, 1'b1, 1'b0);
      run_instr(8, 1'b0, 1'b1);
      // HLT, stay halted 20 cycles, single reset edge
      run_instr(15, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 15, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 15, 1'b0, 1'b0);
      // ADD with run dropped at T1 for three cycles
      cycle(1'b1, 1'b1, 2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
      run_instr(2, 1'b0, 1'b0);
      // every opcode under every flag combination
      for (int o = 0; o < 16; o++) begin
         for (int f = 0; f < 4; f++) begin
            run_instr(o, f[0], f[1]);
            if (mhalted) cycle(1'b0, 1'b1, o, 1'b0, 1'b0);
         end
      end
      // randomized traffic with live opcode changes, run gaps and resets
      op = 0;
      for (int i = 0; i < 1500; i++) begin
         bit clr, r;
         if (mstep == 0 || $urandom_range(0, 15) == 0) op = int'($urandom_range(0, 15));
         clr = !($urandom_range(0, 63) == 0 || (mhalted && $urandom_range(0, 7) == 0));
         r   = ($urandom_range(0, 7) != 0);
         cycle(clr, r, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      #5;
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
